ras_circular: RTL and testbench



---
 rtl/ras_circular_pkg.sv | 38 +++
 rtl/ras_circular_if.sv | 27 ++
 rtl/ras_circular.sv | 130 +++++++++++++
 tb/tb_ras_circular.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ras_circular_pkg.sv
// Shared types for the circular return-address stack and its frontend consumers.
package ras_circular_pkg;

    // Return-address width taken from the core configuration.
    localparam int CORE_VLEN = 64;

    // Top-of-stack view handed to BTB/frontend consumers.
    typedef struct packed {
        logic                 valid;
        logic [CORE_VLEN-1:0] ra;
    } ras_t;

    // Stack operation for one cycle, after priority resolution.
    typedef enum logic [2:0] {
        OP_IDLE,
        OP_FLUSH,
        OP_RESTORE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } ras_op_e;

    // Resolves the request priority: flush > restore > push/pop.
    // Pop on an empty stack is dropped. Push+pop on an empty stack acts as a push.
    function automatic ras_op_e ras_decode(input logic flush, input logic restore,
                                           input logic push, input logic pop,
                                           input logic empty);
        ras_op_e op;
        op = OP_IDLE;
        if (flush)                    op = OP_FLUSH;
        else if (restore)             op = OP_RESTORE;
        else if (push && pop)         op = empty ? OP_PUSH : OP_REPLACE;
        else if (push)                op = OP_PUSH;
        else if (pop && !empty)       op = OP_POP;
        return op;
    endfunction

endpackage

// File: rtl/ras_circular_if.sv
// Request/response bundle between predecode/resolve logic and the RAS.
interface ras_circular_if #(
    parameter int DEPTH = 2,
    parameter int VLEN  = 64
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             flush_bp_i;
    logic             push_i;
    logic             pop_i;
    logic [VLEN-1:0]  data_i;
    logic             ckpt_i;
    logic             restore_i;
    logic [VLEN:0]    data_o;
    logic [CNT_W-1:0] count_o;
    logic             overflow_o;

    modport slave (
        input  flush_bp_i, push_i, pop_i, data_i, ckpt_i, restore_i,
        output data_o, count_o, overflow_o
    );

    modport master (
        output flush_bp_i, push_i, pop_i, data_i, ckpt_i, restore_i,
        input  data_o, count_o, overflow_o
    );
endinterface

// File: rtl/ras_circular.sv
// Circular return-address stack with overwrite-oldest overflow and a
// single-level checkpoint of {tos, count}.
module ras_circular
    import ras_circular_pkg::*;
#(
    parameter  int DEPTH = 2,
    parameter  int VLEN  = CORE_VLEN,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    ras_circular_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam ptr_t PTR_LAST = PTR_W'(DEPTH - 1);
    localparam cnt_t CNT_FULL = CNT_W'(DEPTH);

    logic [VLEN-1:0] mem_q [DEPTH];
    ptr_t            tos_q,        tos_d;
    cnt_t            count_q,      count_d;
    ptr_t            ckpt_tos_q,   ckpt_tos_d;
    cnt_t            ckpt_count_q, ckpt_count_d;
    logic            ovf_q,        ovf_d;

    logic            wr_en;
    ptr_t            wr_ptr;
    ras_op_e         op;

    // Explicit wrap compares so non-power-of-two depths stay in range.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_LAST) ? '0 : ptr_t'(p + 1'b1);
    endfunction

    function automatic ptr_t ptr_dec(input ptr_t p);
        return (p == '0) ? PTR_LAST : ptr_t'(p - 1'b1);
    endfunction

    // Next-state for pointer, occupancy, checkpoint and the memory write port.
    always_comb begin
        op           = ras_decode(bus.flush_bp_i, bus.restore_i, bus.push_i,
                                  bus.pop_i, count_q == '0);
        tos_d        = tos_q;
        count_d      = count_q;
        ckpt_tos_d   = ckpt_tos_q;
        ckpt_count_d = ckpt_count_q;
        ovf_d        = 1'b0;
        wr_en        = 1'b0;
        wr_ptr       = tos_q;

        case (op)
            OP_FLUSH: begin
                tos_d   = '0;
                count_d = '0;
            end
            OP_RESTORE: begin
                tos_d   = ckpt_tos_q;
                count_d = ckpt_count_q;
            end
            OP_PUSH: begin
                tos_d  = ptr_inc(tos_q);
                wr_en  = 1'b1;
                wr_ptr = ptr_inc(tos_q);
                // A full stack keeps its count; the oldest entry is overwritten.
                if (count_q == CNT_FULL) ovf_d   = 1'b1;
                else                     count_d = cnt_t'(count_q + 1'b1);
            end
            OP_POP: begin
                tos_d   = ptr_dec(tos_q);
                count_d = cnt_t'(count_q - 1'b1);
            end
            OP_REPLACE: begin
                wr_en = 1'b1;
            end
            default: ;
        endcase

        // Snapshot is of the state before this cycle's update.
        if (bus.ckpt_i && !bus.flush_bp_i && !bus.restore_i) begin
            ckpt_tos_d   = tos_q;
            ckpt_count_d = count_q;
        end
    end

    // Pointer, occupancy, checkpoint and overflow pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tos_q        <= '0;
            count_q      <= '0;
            ckpt_tos_q   <= '0;
            ckpt_count_q <= '0;
            ovf_q        <= 1'b0;
        end else begin
            tos_q        <= tos_d;
            count_q      <= count_d;
            ckpt_tos_q   <= ckpt_tos_d;
            ckpt_count_q <= ckpt_count_d;
            ovf_q        <= ovf_d;
        end
    end

    // Entry storage; cleared only by reset, never by flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr] <= bus.data_i;
        end
    end

    assign bus.data_o     = {count_q != '0, mem_q[tos_q]};
    assign bus.count_o    = count_q;
    assign bus.overflow_o = ovf_q;

`ifndef SYNTHESIS
    if (DEPTH < 1 || DEPTH > 64) begin : g_depth_chk
        $error("ras_circular: DEPTH out of range 1..64");
    end

    // Occupancy can never exceed the number of entries.
    always @(posedge clk_i) begin
        if (rst_ni) assert (count_q <= CNT_FULL)
            else $error("ras_circular: count exceeds DEPTH");
    end
`endif

endmodule

// File: tb/tb_ras_circular.sv
// Drives four RAS instances (DEPTH 1..4) with the same requests and checks
// each against an array/modulo model of the stack.
module tb_ras_circular;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush, push, pop, ckpt, restore;
    logic [63:0] din;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ras_circular_if #(.DEPTH(1)) bus1 ();
    ras_circular_if #(.DEPTH(2)) bus2 ();
    ras_circular_if #(.DEPTH(3)) bus3 ();
    ras_circular_if #(.DEPTH(4)) bus4 ();

    assign bus1.flush_bp_i = flush; assign bus1.push_i = push; assign bus1.pop_i = pop;
    assign bus1.data_i = din; assign bus1.ckpt_i = ckpt; assign bus1.restore_i = restore;
    assign bus2.flush_bp_i = flush; assign bus2.push_i = push; assign bus2.pop_i = pop;
    assign bus2.data_i = din; assign bus2.ckpt_i = ckpt; assign bus2.restore_i = restore;
    assign bus3.flush_bp_i = flush; assign bus3.push_i = push; assign bus3.pop_i = pop;
    assign bus3.data_i = din; assign bus3.ckpt_i = ckpt; assign bus3.restore_i = restore;
    assign bus4.flush_bp_i = flush; assign bus4.push_i = push; assign bus4.pop_i = pop;
    assign bus4.data_i = din; assign bus4.ckpt_i = ckpt; assign bus4.restore_i = restore;

    ras_circular #(.DEPTH(1)) u_d1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave));
    ras_circular #(.DEPTH(2)) u_d2 (.clk_i(clk), .rst_ni(rst_n), .bus(bus2.slave));
    ras_circular #(.DEPTH(3)) u_d3 (.clk_i(clk), .rst_ni(rst_n), .bus(bus3.slave));
    ras_circular #(.DEPTH(4)) u_d4 (.clk_i(clk), .rst_ni(rst_n), .bus(bus4.slave));

    // Reference model: index k holds the stack of depth k+1.
    logic [63:0] m_mem [4][4];
    int          m_tos [4];
    int          m_cnt [4];
    int          m_ctos[4];
    int          m_ccnt[4];
    bit          m_ovf [4];

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) m_mem[k][j] = '0;
            m_tos[k] = 0; m_cnt[k] = 0; m_ctos[k] = 0; m_ccnt[k] = 0; m_ovf[k] = 0;
        end
    endtask

    task automatic model_update(input bit f, input bit r, input bit pu, input bit po,
                                input bit ck, input logic [63:0] d);
        for (int k = 0; k < 4; k++) begin
            int dep, pre_tos, pre_cnt;
            dep = k + 1;
            pre_tos = m_tos[k];
            pre_cnt = m_cnt[k];
            m_ovf[k] = 0;
            if (f) begin
                m_tos[k] = 0; m_cnt[k] = 0;
            end else if (r) begin
                m_tos[k] = m_ctos[k]; m_cnt[k] = m_ccnt[k];
            end else if (pu && po && pre_cnt > 0) begin
                m_mem[k][pre_tos] = d;
            end else if (pu) begin
                m_ovf[k] = (pre_cnt == dep);
                m_tos[k] = (pre_tos + 1) % dep;
                m_mem[k][m_tos[k]] = d;
                if (pre_cnt < dep) m_cnt[k] = pre_cnt + 1;
            end else if (po && pre_cnt > 0) begin
                m_tos[k] = (pre_tos + dep - 1) % dep;
                m_cnt[k] = pre_cnt - 1;
            end
            if (ck && !f && !r) begin
                m_ctos[k] = pre_tos; m_ccnt[k] = pre_cnt;
            end
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [64:0] d,
                       input int c, input logic o);
        logic [64:0] exp_d;
        exp_d = {m_cnt[k] != 0, m_mem[k][m_tos[k]]};
        total++;
        assert (d === exp_d) else begin
            bad++;
            $error("FAIL %s d%0d data_o observed=%h expected=%h", tag, k + 1, d, exp_d);
        end
        total++;
        assert (c === m_cnt[k]) else begin
            bad++;
            $error("FAIL %s d%0d count_o observed=%0d expected=%0d", tag, k + 1, c, m_cnt[k]);
        end
        total++;
        assert (o === m_ovf[k]) else begin
            bad++;
            $error("FAIL %s d%0d overflow_o observed=%b expected=%b", tag, k + 1, o, m_ovf[k]);
        end
    endtask

    task automatic check_all(input string tag);
        chk(tag, 0, bus1.data_o, int'(bus1.count_o), bus1.overflow_o);
        chk(tag, 1, bus2.data_o, int'(bus2.count_o), bus2.overflow_o);
        chk(tag, 2, bus3.data_o, int'(bus3.count_o), bus3.overflow_o);
        chk(tag, 3, bus4.data_o, int'(bus4.count_o), bus4.overflow_o);
    endtask

    task automatic check_const(input string tag, input logic [64:0] obs, input logic [64:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Called on a falling edge; applies one request and checks after the next rise.
    task automatic step(input string tag, input bit f, input bit r, input bit pu,
                        input bit po, input bit ck, input logic [63:0] d);
        flush = f; restore = r; push = pu; pop = po; ckpt = ck; din = d;
        @(posedge clk);
        model_update(f, r, pu, po, ck, d);
        @(negedge clk);
        flush = 0; restore = 0; push = 0; pop = 0; ckpt = 0; din = '0;
        check_all(tag);
    endtask

    task automatic do_push(input string tag, input logic [63:0] d);
        step(tag, 0, 0, 1, 0, 0, d);
    endtask

    task automatic do_pop(input string tag);
        step(tag, 0, 0, 0, 1, 0, '0);
    endtask

    initial begin
        flush = 0; push = 0; pop = 0; ckpt = 0; restore = 0; din = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("idle");

        // Basic push/pop
        do_push("push1", 64'h1000);
        do_push("push2", 64'h2000);
        check_const("d2_top_2000", bus2.data_o, {1'b1, 64'h2000});
        check_const("d2_count_2", 65'(bus2.count_o), 65'd2);
        do_pop("pop1");
        check_const("d2_top_1000", bus2.data_o, {1'b1, 64'h1000});
        do_pop("pop2");
        do_pop("pop_under");
        check_const("d2_empty", 65'(bus2.data_o[64]), 65'd0);

        // Overflow
        do_push("ovf_a", 64'hA);
        do_push("ovf_b", 64'hB);
        do_push("ovf_c", 64'hC);
        check_const("d2_ovf_pulse", 65'(bus2.overflow_o), 65'd1);
        do_pop("ovf_pop1");
        check_const("d2_ovf_clear", 65'(bus2.overflow_o), 65'd0);
        do_pop("ovf_pop2");
        do_pop("ovf_pop3");

        // Simultaneous push/pop
        step("flush1", 1, 0, 0, 0, 0, '0);
        do_push("pp_10", 64'h10);
        do_push("pp_20", 64'h20);
        step("pp_repl", 0, 0, 1, 1, 0, 64'h30);
        check_const("d3_top_30", bus3.data_o, {1'b1, 64'h30});
        do_pop("pp_pop");
        check_const("d3_top_10", bus3.data_o, {1'b1, 64'h10});
        step("flush2", 1, 0, 0, 0, 0, '0);
        step("pp_empty", 0, 0, 1, 1, 0, 64'h40);

        // Checkpoint/restore
        step("flush3", 1, 0, 0, 0, 0, '0);
        do_push("ck_1", 64'h1);
        do_push("ck_2", 64'h2);
        step("ck_snap", 0, 0, 0, 0, 1, '0);
        do_push("ck_3", 64'h3);
        do_pop("ck_pop1");
        do_pop("ck_pop2");
        step("ck_restore", 0, 1, 0, 0, 0, '0);
        check_const("d4_restore_top", bus4.data_o, {1'b1, 64'h2});
        step("ck_with_push", 0, 0, 1, 0, 1, 64'h5);
        do_push("ck_6", 64'h6);
        step("ck_restore2", 0, 1, 0, 0, 0, '0);
        check_const("d4_restore2_cnt", 65'(bus4.count_o), 65'd2);

        // Priority
        step("prio_all", 1, 1, 1, 0, 1, 64'h77);
        do_push("prio_p1", 64'h88);
        step("prio_ck", 0, 0, 0, 0, 1, '0);
        do_push("prio_p2", 64'h99);
        step("prio_rp", 0, 1, 1, 0, 0, 64'hAA);

        // Non-power-of-two wrap
        step("flush4", 1, 0, 0, 0, 0, '0);
        for (int i = 1; i <= 7; i++) do_push("wrap_push", 64'(i));
        check_const("d3_wrap_top", bus3.data_o, {1'b1, 64'h7});
        do_pop("wrap_pop1");
        do_pop("wrap_pop2");
        check_const("d3_wrap_5", bus3.data_o, {1'b1, 64'h5});
        do_pop("wrap_pop3");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit rf, rr, rpu, rpo, rck;
            rf  = ($urandom_range(0, 24) == 0);
            rr  = ($urandom_range(0, 9) == 0);
            rpu = ($urandom_range(0, 1) == 1);
            rpo = ($urandom_range(0, 2) == 0);
            rck = ($urandom_range(0, 5) == 0);
            step("rand", rf, rr, rpu, rpo, rck, {$urandom, $urandom});
        end

        // Reset mid-sequence discards everything, checkpoint included
        do_push("pre_rst1", 64'h123);
        step("pre_rst_ck", 0, 0, 1, 0, 1, 64'h456);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        do_push("post_rst", 64'hBEEF);
        step("post_rst_restore", 0, 1, 0, 0, 0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
